// File: rtl/noc_flit_checker_pkg.sv
// Shared NoC definitions: header layout, payload pattern, error-bit indices,
// checker FSM encoding and the backpressure LFSR polynomial.
package noc_flit_checker_pkg;

  // Low 32 bits of a header flit; bits above 31 carry nothing.
  typedef struct packed {
    logic [3:0] dst_x;
    logic [3:0] dst_y;
    logic [3:0] src_x;
    logic [3:0] src_y;
    logic [7:0] seq;
    logic [7:0] len;
  } hdr_t;

  localparam int ERR_DEST         = 0;
  localparam int ERR_NO_HEADER    = 1;
  localparam int ERR_EARLY_HEADER = 2;
  localparam int ERR_LENGTH       = 3;
  localparam int ERR_PAYLOAD      = 4;
  localparam int ERR_W            = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Fibonacci taps 8,6,5,4 mapped onto state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Payload flit k of packet seq: {seq, k} in the low 16 bits, zero above.
  function automatic logic [15:0] payload_pattern(input logic [7:0] seq, input logic [7:0] k);
    return {seq, k};
  endfunction

endpackage

// File: rtl/noc_lfsr8.sv
// 8-bit Fibonacci LFSR with enable and synchronous reset; exposes the bit
// that the LSB will take on the coming edge.
module noc_lfsr8
  import noc_flit_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic next_lsb
);

  logic [7:0] state;
  logic [7:0] state_n;

  assign state_n  = en ? {state[6:0], ^(state & LFSR_TAPS)} : state;
  assign next_lsb = state_n[0];

  always_ff @(posedge clk) begin
    if (rst) state <= LFSR_SEED;
    else     state <= state_n;
  end

endmodule

// File: rtl/noc_flit_checker.sv
// Receive endpoint for NoC test traffic: checks routing, framing, length and
// payload pattern per packet and keeps good/error statistics.
module noc_flit_checker
  import noc_flit_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  input  logic              stall_en,
  output logic              pkt_done,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count,
  output logic [ERR_W-1:0]  err_flags,
  output logic [7:0]        last_src,
  output logic [7:0]        last_seq,
  output logic [1:0]        fsm_state
);

  // Handshake: a flit transfers on a rising edge where receive_valid and
  // receive_ready are both 1; ready is a register and never looks at valid.

  logic [1:0]       state, state_n;
  logic [7:0]       k, k_n;
  logic [7:0]       seq_q, seq_n;
  logic [7:0]       len_q, len_n;
  logic [7:0]       src_q, src_n;
  logic             pkt_err, pkt_err_n;
  logic [ERR_W-1:0] flag_set;
  logic [1:0]       err_inc;
  logic             good;
  logic [7:0]       good_src, good_seq;
  logic             accept;
  logic             lfsr_bit;
  logic             dst_hit, pay_err, len_err;
  logic [16:0]      err_sum;
  hdr_t             hdr;

  noc_lfsr8 u_lfsr (
    .clk      (noc_clk),
    .rst      (noc_rst),
    .en       (1'b1),
    .next_lsb (lfsr_bit)
  );

  assign accept    = receive_valid & receive_ready;
  assign hdr       = hdr_t'(receive_flit[31:0]);
  assign dst_hit   = (hdr.dst_x == 4'(X_ID)) && (hdr.dst_y == 4'(Y_ID));
  assign pay_err   = receive_flit != DATA_W'(payload_pattern(seq_q, k));
  assign len_err   = receive_is_tail ? (k != len_q) : (k == len_q);
  assign err_sum   = {1'b0, err_count} + {15'b0, err_inc};
  assign fsm_state = state;

  always_comb begin
    state_n   = state;
    k_n       = k;
    seq_n     = seq_q;
    len_n     = len_q;
    src_n     = src_q;
    pkt_err_n = pkt_err;
    flag_set  = '0;
    err_inc   = 2'd0;
    good      = 1'b0;
    good_src  = src_q;
    good_seq  = seq_q;
    if (accept) begin
      if (receive_is_header) begin
        // A header mid-body aborts the open packet, then starts a fresh one.
        if (state == ST_BODY) begin
          flag_set[ERR_EARLY_HEADER] = 1'b1;
          if (!pkt_err) err_inc = 2'd1;
        end
        pkt_err_n = 1'b0;
        if (!dst_hit) begin
          flag_set[ERR_DEST] = 1'b1;
          err_inc   = err_inc + 2'd1;
          pkt_err_n = 1'b1;
          state_n   = receive_is_tail ? ST_IDLE : ST_DRAIN;
        end else begin
          seq_n = hdr.seq;
          len_n = hdr.len;
          src_n = {hdr.src_x, hdr.src_y};
          k_n   = 8'd1;
          if (hdr.len == 8'd0 && receive_is_tail) begin
            good     = 1'b1;
            good_src = {hdr.src_x, hdr.src_y};
            good_seq = hdr.seq;
            state_n  = ST_IDLE;
          end else begin
            state_n = receive_is_tail ? ST_IDLE : ST_BODY;
            if (receive_is_tail || hdr.len == 8'd0) begin
              flag_set[ERR_LENGTH] = 1'b1;
              err_inc   = err_inc + 2'd1;
              pkt_err_n = 1'b1;
            end
          end
        end
      end else begin
        case (state)
          ST_IDLE: begin
            flag_set[ERR_NO_HEADER] = 1'b1;
            err_inc   = 2'd1;
            pkt_err_n = 1'b1;
            state_n   = receive_is_tail ? ST_IDLE : ST_DRAIN;
          end
          ST_BODY: begin
            flag_set[ERR_PAYLOAD] = pay_err;
            flag_set[ERR_LENGTH]  = len_err;
            if (pay_err || len_err) begin
              pkt_err_n = 1'b1;
              if (!pkt_err) err_inc = 2'd1;
            end
            if (receive_is_tail) begin
              state_n = ST_IDLE;
              good    = !(pkt_err || pay_err || len_err);
            end else if (k == len_q) begin
              state_n = ST_DRAIN;
            end else begin
              k_n = k + 8'd1;
            end
          end
          default: begin
            if (receive_is_tail) state_n = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state         <= ST_IDLE;
      k             <= 8'd0;
      seq_q         <= 8'd0;
      len_q         <= 8'd0;
      src_q         <= 8'd0;
      pkt_err       <= 1'b0;
      receive_ready <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_count     <= 16'd0;
      err_count     <= 16'd0;
      err_flags     <= '0;
      last_src      <= 8'd0;
      last_seq      <= 8'd0;
    end else begin
      state         <= state_n;
      k             <= k_n;
      seq_q         <= seq_n;
      len_q         <= len_n;
      src_q         <= src_n;
      pkt_err       <= pkt_err_n;
      receive_ready <= stall_en ? lfsr_bit : 1'b1;
      pkt_done      <= good;
      err_flags     <= err_flags | flag_set;
      err_count     <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (good) begin
        pkt_count <= pkt_count + 16'd1;
        last_src  <= good_src;
        last_seq  <= good_seq;
      end
    end
  end

endmodule

// File: tb/tb_noc_flit_checker.sv
// Bench for noc_flit_checker at node (1,1): directed cases followed by random
// packets whose outcome is predicted per packet from its intended fault.
module tb_noc_flit_checker;

  localparam int W = 32;
  localparam int K_GOOD = 0, K_DEST = 1, K_NOHDR = 2, K_SHORT = 3;
  localparam int K_LONG = 4, K_HDRTAIL = 5, K_PAY = 6, K_EARLY = 7;

  logic          noc_clk = 1'b0;
  logic          noc_rst;
  logic          receive_valid;
  logic          receive_ready;
  logic [W-1:0]  receive_flit;
  logic          receive_is_header;
  logic          receive_is_tail;
  logic          stall_en;
  logic          pkt_done;
  logic [15:0]   pkt_count;
  logic [15:0]   err_count;
  logic [4:0]    err_flags;
  logic [7:0]    last_src;
  logic [7:0]    last_seq;
  logic [1:0]    fsm_state;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_q[$];
  int            exp_pkt = 0;
  int            exp_err = 0;
  int            exp_done = 0;
  int            done_seen = 0;
  logic [4:0]    exp_flags = '0;

  noc_flit_checker #(.DATA_W(W), .X_ID(1), .Y_ID(1)) dut (
    .noc_clk           (noc_clk),
    .noc_rst           (noc_rst),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .stall_en          (stall_en),
    .pkt_done          (pkt_done),
    .pkt_count         (pkt_count),
    .err_count         (err_count),
    .err_flags         (err_flags),
    .last_src          (last_src),
    .last_seq          (last_seq),
    .fsm_state         (fsm_state)
  );

  // Clock / watchdog
  always #5 noc_clk = ~noc_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pkt_done pulse consumes one expected {src, seq}.
  always @(negedge noc_clk) begin
    if (pkt_done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) check("pending_good", 32'(exp_q.size()), 32'd1);
      else check("last_src_seq", {16'h0, last_src, last_seq}, {16'h0, exp_q.pop_front()});
    end
  end

  function automatic logic [31:0] mk_hdr(input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [3:0] sx, input logic [3:0] sy,
                                         input logic [7:0] seq, input logic [7:0] len);
    return {dx, dy, sx, sy, seq, len};
  endfunction

  function automatic logic [31:0] pay(input logic [7:0] seq, input int k);
    return {16'h0, seq, 8'(k)};
  endfunction

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic idle(input int n);
    receive_valid = 1'b0;
    repeat (n) @(negedge noc_clk);
  endtask

  task automatic send_flit(input logic [31:0] d, input logic h, input logic t);
    int waited = 0;
    receive_valid     = 1'b1;
    receive_flit      = d;
    receive_is_header = h;
    receive_is_tail   = t;
    while (receive_ready !== 1'b1 && waited < 400) begin
      @(negedge noc_clk);
      waited++;
    end
    if (receive_ready !== 1'b1) check("accept_timeout", {31'b0, receive_ready}, 32'd1);
    else @(negedge noc_clk);
    receive_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    noc_rst       = 1'b1;
    receive_valid = 1'b0;
    repeat (n) @(negedge noc_clk);
    check("rst_ready", {31'b0, receive_ready}, 32'd0);
    check("rst_done", {31'b0, pkt_done}, 32'd0);
    check("rst_pkt_count", {16'h0, pkt_count}, 32'd0);
    check("rst_err_count", {16'h0, err_count}, 32'd0);
    check("rst_err_flags", {27'h0, err_flags}, 32'd0);
    check("rst_last_src", {24'h0, last_src}, 32'd0);
    check("rst_last_seq", {24'h0, last_seq}, 32'd0);
    check("rst_fsm_idle", {30'h0, fsm_state}, 32'd0);
    noc_rst   = 1'b0;
    exp_pkt   = 0;
    exp_err   = 0;
    exp_flags = '0;
    exp_q.delete();
    @(negedge noc_clk);
  endtask

  task automatic check_counts(input string tag);
    idle(1);
    check({tag, "_pkt_count"}, {16'h0, pkt_count}, 32'(exp_pkt));
    check({tag, "_err_count"}, {16'h0, err_count}, 32'(exp_err));
    check({tag, "_err_flags"}, {27'h0, err_flags}, {27'h0, exp_flags});
    check({tag, "_done_pulses"}, 32'(done_seen), 32'(exp_done));
  endtask

  task automatic expect_good(input logic [7:0] src, input logic [7:0] seq);
    exp_q.push_back({src, seq});
    exp_pkt++;
    exp_done++;
  endtask

  task automatic expect_err(input int bit_idx);
    exp_flags[bit_idx] = 1'b1;
    exp_err++;
  endtask

  task automatic send_good(input logic [3:0] sx, input logic [3:0] sy,
                           input logic [7:0] seq, input int len);
    expect_good({sx, sy}, seq);
    send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'(len)), 1'b1, len == 0);
    for (int k = 1; k <= len; k++) send_flit(pay(seq, k), 1'b0, k == len);
  endtask

  // One packet of the given kind; the model is updated from the kind alone.
  task automatic run_packet(input int kind);
    logic [3:0] sx, sy, dx, dy;
    logic [7:0] seq;
    logic [31:0] d;
    int len, m, n, j;
    sx  = 4'($urandom_range(0, 15));
    sy  = 4'($urandom_range(0, 15));
    seq = 8'($urandom_range(0, 255));
    case (kind)
      K_GOOD: send_good(sx, sy, seq, $urandom_range(0, 5));
      K_DEST: begin
        do begin
          dx = 4'($urandom_range(0, 15));
          dy = 4'($urandom_range(0, 15));
        end while (dx == 4'd1 && dy == 4'd1);
        n = $urandom_range(0, 3);
        expect_err(0);
        send_flit(mk_hdr(dx, dy, sx, sy, seq, 8'(n)), 1'b1, n == 0);
        for (int i = 1; i <= n; i++) send_flit($urandom, 1'b0, i == n);
      end
      K_NOHDR: begin
        n = $urandom_range(1, 3);
        expect_err(1);
        for (int i = 1; i <= n; i++) send_flit($urandom, 1'b0, i == n);
      end
      K_SHORT: begin
        len = $urandom_range(2, 6);
        m   = $urandom_range(1, len - 1);
        expect_err(3);
        send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'(len)), 1'b1, 1'b0);
        for (int k = 1; k <= m; k++) send_flit(pay(seq, k), 1'b0, k == m);
      end
      K_LONG: begin
        len = $urandom_range(1, 4);
        n   = $urandom_range(1, 2);
        expect_err(3);
        send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'(len)), 1'b1, 1'b0);
        for (int k = 1; k <= len; k++) send_flit(pay(seq, k), 1'b0, 1'b0);
        for (int i = 1; i <= n; i++) send_flit($urandom, 1'b0, i == n);
      end
      K_HDRTAIL: begin
        expect_err(3);
        send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'($urandom_range(1, 5))), 1'b1, 1'b1);
      end
      K_PAY: begin
        len = $urandom_range(1, 5);
        j   = $urandom_range(1, len);
        expect_err(4);
        send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'(len)), 1'b1, 1'b0);
        for (int k = 1; k <= len; k++) begin
          d = pay(seq, k);
          if (k == j) d = d ^ (32'd1 << $urandom_range(0, 31));
          send_flit(d, 1'b0, k == len);
        end
      end
      default: begin
        len = $urandom_range(1, 5);
        m   = $urandom_range(0, len - 1);
        expect_err(2);
        send_flit(mk_hdr(4'd1, 4'd1, sx, sy, seq, 8'(len)), 1'b1, 1'b0);
        for (int k = 1; k <= m; k++) send_flit(pay(seq, k), 1'b0, 1'b0);
      end
    endcase
  endtask

  initial begin
    int kind;
    int prev;
    noc_rst           = 1'b1;
    receive_valid     = 1'b0;
    receive_flit      = '0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    stall_en          = 1'b0;
    @(negedge noc_clk);
    do_reset(3);
    check("ready_after_reset", {31'b0, receive_ready}, 32'd1);

    // Reference 3-flit packet, no backpressure
    expect_good(8'h00, 8'h05);
    send_flit(32'h1100_0503, 1'b1, 1'b0);
    send_flit(32'h0000_0501, 1'b0, 1'b0);
    send_flit(32'h0000_0502, 1'b0, 1'b0);
    send_flit(32'h0000_0503, 1'b0, 1'b1);
    check_counts("basic");
    check("basic_last_src", {24'h0, last_src}, 32'h00);
    check("basic_last_seq", {24'h0, last_seq}, 32'h05);

    // Same packet under pseudo-random backpressure
    stall_en = 1'b1;
    send_good(4'd0, 4'd0, 8'h05, 3);
    check_counts("stall");
    stall_en = 1'b0;

    // Wrong destination, drained body, then a good packet
    expect_err(0);
    send_flit(32'h0100_0702, 1'b1, 1'b0);
    send_flit(32'h0000_0701, 1'b0, 1'b0);
    send_flit(32'h0000_0702, 1'b0, 1'b1);
    check_counts("dest");
    send_good(4'd2, 4'd3, 8'h06, 2);
    check_counts("after_dest");

    // Tail at k=2 of len 3, next header straight after
    expect_err(3);
    send_flit(32'h1100_0803, 1'b1, 1'b0);
    send_flit(32'h0000_0801, 1'b0, 1'b0);
    send_flit(32'h0000_0802, 1'b0, 1'b1);
    check("short_fsm_idle", {30'h0, fsm_state}, 32'd0);
    send_good(4'd0, 4'd0, 8'h0A, 2);
    check_counts("short");

    // Corrupted second payload
    expect_err(4);
    send_flit(32'h1100_0503, 1'b1, 1'b0);
    send_flit(32'h0000_0501, 1'b0, 1'b0);
    send_flit(32'h0000_0509, 1'b0, 1'b0);
    send_flit(32'h0000_0503, 1'b0, 1'b1);
    check_counts("payload");

    // Reset in the middle of a packet
    send_flit(32'h1100_0603, 1'b1, 1'b0);
    send_flit(32'h0000_0601, 1'b0, 1'b0);
    do_reset(2);
    send_good(4'd4, 4'd5, 8'h07, 3);
    check_counts("after_reset");

    // Random packet mix
    prev = K_GOOD;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind > K_EARLY) kind = K_GOOD;
      if (prev == K_EARLY && kind == K_NOHDR) kind = K_GOOD;
      stall_en = ($urandom_range(0, 1) == 1);
      run_packet(kind);
      if (kind != K_EARLY) check_counts("rand");
      idle($urandom_range(0, 2));
      prev = kind;
    end
    run_packet(K_GOOD);
    check_counts("final");
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
